// File: rtl/timer_host_master.sv
// Avalon-MM initiator for the interval timer.
// Programs period/control and services each timer IRQ in hardware.
module timer_host_master #(
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_continuous,
   input  logic              cmd_irq_en,
   output logic [2:0]        m_address,
   output logic              m_chipselect,
   output logic              m_write_n,
   output logic [15:0]       m_writedata,
   input  logic              m_waitrequest,
   input  logic [15:0]       m_readdata,
   input  logic              timer_irq,
   output logic              evt_valid,
   output logic [31:0]       evt_snapshot,
   output logic [CNT_W-1:0]  evt_count,
   output logic              busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_P_L,
      S_P_H,
      S_CTRL,
      S_CLR,
      S_SNAP,
      S_RD_L,
      S_WT_L,
      S_RD_H,
      S_WT_H,
      S_EMIT
   } state_t;

   localparam logic [1:0] LAT = 2'(READ_LATENCY);

   state_t       state;
   state_t       state_nx;
   logic         run_q;
   logic         take_cmd;
   logic         wt_done;
   logic [1:0]   wt_cnt;
   logic [31:0]  period_q;
   logic         cont_q;
   logic         ien_q;
   logic [15:0]  snap_l_q;
   logic [15:0]  period_lo;

   logic         cs_nx;
   logic         wn_nx;
   logic [2:0]   addr_nx;
   logic [15:0]  wd_nx;

   // IRQ has priority; a command is only taken when it is offered ready.
   assign cmd_ready = run_q & (state == S_IDLE) & ~timer_irq;

   assign wt_done   = (wt_cnt == LAT);

   // P_L is issued in the same edge that captures the command.
   assign period_lo = take_cmd ? cmd_period[15:0] : period_q[15:0];

   // Next-state selection; bus states advance only without waitrequest.
   always_comb begin
      state_nx = state;
      take_cmd = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (run_q) begin
               if (timer_irq) begin
                  state_nx = S_CLR;
               end else if (cmd_valid) begin
                  state_nx = S_P_L;
                  take_cmd = 1'b1;
               end
            end
         end
         S_P_L:  if (!m_waitrequest) state_nx = S_P_H;
         S_P_H:  if (!m_waitrequest) state_nx = S_CTRL;
         S_CTRL: if (!m_waitrequest) state_nx = S_IDLE;
         S_CLR:  if (!m_waitrequest) state_nx = S_SNAP;
         S_SNAP: if (!m_waitrequest) state_nx = S_RD_L;
         S_RD_L: if (!m_waitrequest) state_nx = S_WT_L;
         S_WT_L: if (wt_done) state_nx = S_RD_H;
         S_RD_H: if (!m_waitrequest) state_nx = S_WT_H;
         S_WT_H: if (wt_done) state_nx = S_EMIT;
         S_EMIT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Bus values for the state being entered, so they can be registered.
   always_comb begin
      cs_nx   = 1'b0;
      wn_nx   = 1'b1;
      addr_nx = 3'd0;
      wd_nx   = 16'h0000;
      unique case (state_nx)
         S_P_L: begin
            cs_nx   = 1'b1;
            wn_nx   = 1'b0;
            addr_nx = 3'd2;
            wd_nx   = period_lo;
         end
         S_P_H: begin
            cs_nx   = 1'b1;
            wn_nx   = 1'b0;
            addr_nx = 3'd3;
            wd_nx   = period_q[31:16];
         end
         S_CTRL: begin
            cs_nx   = 1'b1;
            wn_nx   = 1'b0;
            addr_nx = 3'd1;
            wd_nx   = {12'h000, 1'b0, 1'b1, cont_q, ien_q};
         end
         S_CLR: begin
            cs_nx   = 1'b1;
            wn_nx   = 1'b0;
            addr_nx = 3'd0;
         end
         S_SNAP: begin
            cs_nx   = 1'b1;
            wn_nx   = 1'b0;
            addr_nx = 3'd4;
         end
         S_RD_L: begin
            cs_nx   = 1'b1;
            addr_nx = 3'd4;
         end
         S_RD_H: begin
            cs_nx   = 1'b1;
            addr_nx = 3'd5;
         end
         default: begin
            cs_nx   = 1'b0;
         end
      endcase
   end

   // State register plus the one-shot run flag gating cmd_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         run_q <= 1'b0;
      end else begin
         state <= state_nx;
         run_q <= 1'b1;
      end
   end

   // Command capture and read-latency wait counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_q <= 32'h0;
         cont_q   <= 1'b0;
         ien_q    <= 1'b0;
         wt_cnt   <= 2'd0;
         snap_l_q <= 16'h0;
      end else begin
         if (take_cmd) begin
            period_q <= cmd_period;
            cont_q   <= cmd_continuous;
            ien_q    <= cmd_irq_en;
         end
         if ((state == S_WT_L || state == S_WT_H) && !wt_done)
            wt_cnt <= wt_cnt + 2'd1;
         else
            wt_cnt <= 2'd0;
         if (state == S_WT_L && wt_done)
            snap_l_q <= m_readdata;
      end
   end

   // Registered bus, event and status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_address    <= 3'd0;
         m_writedata  <= 16'h0;
         evt_valid    <= 1'b0;
         evt_snapshot <= 32'h0;
         evt_count    <= '0;
         busy         <= 1'b0;
      end else begin
         m_chipselect <= cs_nx;
         m_write_n    <= wn_nx;
         m_address    <= addr_nx;
         m_writedata  <= wd_nx;
         evt_valid    <= (state_nx == S_EMIT);
         busy         <= (state_nx != S_IDLE);
         if (state == S_WT_H && wt_done) begin
            evt_snapshot <= {m_readdata, snap_l_q};
            evt_count    <= evt_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_timer_host_master.sv
// Directed bench for timer_host_master.
// Two instances: READ_LATENCY=1/CNT_W=16 and READ_LATENCY=3/CNT_W=4.
module tb_timer_host_master;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   // instance 0
   logic        cmd_valid = 1'b0;
   logic        cmd_ready0;
   logic [31:0] cmd_period = 32'h0;
   logic        cmd_cont = 1'b0;
   logic        cmd_ien = 1'b0;
   logic [2:0]  addr0;
   logic        cs0, wn0;
   logic [15:0] wd0;
   logic        wait0 = 1'b0;
   logic [15:0] rd0;
   logic        irq0;
   logic        ev0;
   logic [31:0] snap_o0;
   logic [15:0] cnt0;
   logic        busy0;

   // instance 1
   logic        cv1 = 1'b0;
   logic        cmd_ready1;
   logic [31:0] cp1 = 32'h0;
   logic        cc1 = 1'b0;
   logic        ci1 = 1'b0;
   logic [2:0]  addr1;
   logic        cs1, wn1;
   logic [15:0] wd1;
   logic        wait1 = 1'b0;
   logic [15:0] rd1;
   logic        irq1;
   logic        ev1;
   logic [31:0] snap_o1;
   logic [3:0]  cnt1;
   logic        busy1;

   timer_host_master #(.READ_LATENCY(1), .CNT_W(16)) u0 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
      .cmd_period(cmd_period), .cmd_continuous(cmd_cont),
      .cmd_irq_en(cmd_ien),
      .m_address(addr0), .m_chipselect(cs0), .m_write_n(wn0),
      .m_writedata(wd0), .m_waitrequest(wait0), .m_readdata(rd0),
      .timer_irq(irq0), .evt_valid(ev0), .evt_snapshot(snap_o0),
      .evt_count(cnt0), .busy(busy0)
   );

   timer_host_master #(.READ_LATENCY(3), .CNT_W(4)) u1 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cv1), .cmd_ready(cmd_ready1),
      .cmd_period(cp1), .cmd_continuous(cc1),
      .cmd_irq_en(ci1),
      .m_address(addr1), .m_chipselect(cs1), .m_write_n(wn1),
      .m_writedata(wd1), .m_waitrequest(wait1), .m_readdata(rd1),
      .timer_irq(irq1), .evt_valid(ev1), .evt_snapshot(snap_o1),
      .evt_count(cnt1), .busy(busy1)
   );

   // timer slave models
   logic        irq_req0 = 1'b0;
   logic        irq_req1 = 1'b0;
   logic [31:0] tsnap0 = 32'h0;
   logic [31:0] tsnap1 = 32'h0;
   logic [15:0] pipe1 [3];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq0 <= 1'b0;
         rd0  <= 16'h0;
      end else begin
         if (irq_req0)
            irq0 <= 1'b1;
         else if (cs0 && !wait0 && !wn0 && addr0 == 3'd0)
            irq0 <= 1'b0;
         if (cs0 && !wait0 && wn0)
            rd0 <= (addr0 == 3'd4) ? tsnap0[15:0] :
                   (addr0 == 3'd5) ? tsnap0[31:16] : 16'h0;
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq1 <= 1'b0;
         pipe1[0] <= 16'h0;
         pipe1[1] <= 16'h0;
         pipe1[2] <= 16'h0;
      end else begin
         if (irq_req1)
            irq1 <= 1'b1;
         else if (cs1 && !wait1 && !wn1 && addr1 == 3'd0)
            irq1 <= 1'b0;
         if (cs1 && !wait1 && wn1)
            pipe1[0] <= (addr1 == 3'd4) ? tsnap1[15:0] :
                        (addr1 == 3'd5) ? tsnap1[31:16] : 16'h0;
         pipe1[1] <= pipe1[0];
         pipe1[2] <= pipe1[1];
      end
   end
   assign rd1 = pipe1[2];

   // monitors
   typedef struct {
      logic        wr;
      logic [2:0]  a;
      logic [15:0] d;
      int          c;
   } xfer_t;
   xfer_t log0[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (reset_n && cs0 && !wait0)
         log0.push_back('{wr: !wn0, a: addr0, d: wd0, c: cyc});

   int   t_irq0 = 0, t_ev0 = 0, n_ev0 = 0;
   int   t_irq1 = 0, t_ev1 = 0, n_ev1 = 0;
   logic irq0_p = 1'b0, irq1_p = 1'b0;

   always @(negedge clk) begin
      irq0_p <= irq0;
      irq1_p <= irq1;
      if (irq0 && !irq0_p) t_irq0 <= cyc;
      if (irq1 && !irq1_p) t_irq1 <= cyc;
      if (ev0) begin
         t_ev0 <= cyc;
         n_ev0 <= n_ev0 + 1;
      end
      if (ev1) begin
         t_ev1 <= cyc;
         n_ev1 <= n_ev1 + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic raise0();
      irq_req0 = 1'b1;
      tick();
      irq_req0 = 1'b0;
   endtask

   task automatic raise1();
      irq_req1 = 1'b1;
      tick();
      irq_req1 = 1'b0;
   endtask

   task automatic wait_ev0(input int n0);
      int k = 0;
      while (n_ev0 == n0 && k < 40) begin
         tick();
         k++;
      end
      chk("ev0_timeout", 32'(n_ev0 != n0), 32'd1);
   endtask

   task automatic wait_ev1(input int n0);
      int k = 0;
      while (n_ev1 == n0 && k < 40) begin
         tick();
         k++;
      end
      chk("ev1_timeout", 32'(n_ev1 != n0), 32'd1);
   endtask

   task automatic wait_idle0();
      int k = 0;
      while (busy0 && k < 50) begin
         tick();
         k++;
      end
      chk("idle_timeout", 32'(busy0), 32'd0);
   endtask

   task automatic prog0(input logic [31:0] p, input logic c,
                        input logic e);
      int k = 0;
      cmd_period = p;
      cmd_cont   = c;
      cmd_ien    = e;
      cmd_valid  = 1'b1;
      while (!cmd_ready0 && k < 50) begin
         tick();
         k++;
      end
      chk("cmd_accept_timeout", 32'(cmd_ready0), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] p;
      logic        c;
      logic        e;
      logic [15:0] dl;
      logic [15:0] dh;
      logic [15:0] dc;
   } pvec_t;

   typedef struct {
      logic [31:0] snap;
      logic [15:0] cnt;
   } svec_t;

   pvec_t pv[4];
   svec_t sv[3];
   logic       s_wr[4];
   logic [2:0] s_a[4];

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      pv[0] = '{32'h000186A0, 1'b1, 1'b1, 16'h86A0, 16'h0001, 16'h0007};
      pv[1] = '{32'hDEADBEEF, 1'b0, 1'b1, 16'hBEEF, 16'hDEAD, 16'h0005};
      pv[2] = '{32'h00000010, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0006};
      pv[3] = '{32'h00000000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0004};
      sv[0] = '{32'h00001234, 16'd1};
      sv[1] = '{32'hA5A55A5A, 16'd2};
      sv[2] = '{32'h00000000, 16'd3};
      s_wr = '{1'b1, 1'b1, 1'b0, 1'b0};
      s_a  = '{3'd0, 3'd4, 3'd4, 3'd5};

      // reset values
      tick();
      tick();
      chk("rst_cs", 32'(cs0), 32'd0);
      chk("rst_write_n", 32'(wn0), 32'd1);
      chk("rst_addr", 32'(addr0), 32'd0);
      chk("rst_wdata", 32'(wd0), 32'd0);
      chk("rst_evt", {ev0, busy0, cmd_ready0}, 32'd0);
      chk("rst_snap", snap_o0, 32'd0);
      chk("rst_count", 32'(cnt0), 32'd0);
      reset_n = 1'b1;
      tick();
      tick();
      chk("ready_after_rst", 32'(cmd_ready0), 32'd1);

      // program vectors
      foreach (pv[i]) begin
         log0.delete();
         prog0(pv[i].p, pv[i].c, pv[i].e);
         wait_idle0();
         chk("prog_nxfer", log0.size(), 32'd3);
         if (log0.size() == 3) begin
            chk("prog_pl", {log0[0].wr, 13'h0, log0[0].a, log0[0].d},
                {1'b1, 13'h0, 3'd2, pv[i].dl});
            chk("prog_ph", {log0[1].wr, 13'h0, log0[1].a, log0[1].d},
                {1'b1, 13'h0, 3'd3, pv[i].dh});
            chk("prog_ctrl", {log0[2].wr, 13'h0, log0[2].a, log0[2].d},
                {1'b1, 13'h0, 3'd1, pv[i].dc});
            chk("prog_back2back", log0[2].c - log0[0].c, 32'd2);
         end
      end

      // service vectors
      foreach (sv[i]) begin
         tsnap0 = sv[i].snap;
         log0.delete();
         n = n_ev0;
         raise0();
         wait_ev0(n);
         chk("svc_latency", t_ev0 - t_irq0, 32'd9);
         chk("svc_snapshot", snap_o0, sv[i].snap);
         chk("svc_count", 32'(cnt0), 32'(sv[i].cnt));
         chk("svc_nxfer", log0.size(), 32'd4);
         if (log0.size() == 4) begin
            for (int j = 0; j < 4; j++)
               chk("svc_bus", {log0[j].wr, 13'h0, log0[j].a, log0[j].d},
                   {s_wr[j], 13'h0, s_a[j], 16'h0});
         end
         tick();
         chk("svc_pulse_1cyc", 32'(ev0), 32'd0);
         chk("svc_snap_hold", snap_o0, sv[i].snap);
         wait_idle0();
      end

      // irq and command in the same IDLE cycle
      tsnap0 = 32'h0BADF00D;
      log0.delete();
      n = n_ev0;
      raise0();
      cmd_period = 32'h00020003;
      cmd_cont   = 1'b0;
      cmd_ien    = 1'b1;
      cmd_valid  = 1'b1;
      chk("sim_ready_low", 32'(cmd_ready0), 32'd0);
      wait_ev0(n);
      chk("sim_snapshot", snap_o0, 32'h0BADF00D);
      chk("sim_count", 32'(cnt0), 32'd4);
      tick();
      chk("sim_ready_after_emit", 32'(cmd_ready0), 32'd1);
      tick();
      cmd_valid = 1'b0;
      wait_idle0();
      chk("sim_nxfer", log0.size(), 32'd7);
      if (log0.size() == 7) begin
         chk("sim_first_clr", 32'(log0[0].a), 32'd0);
         chk("sim_pl", {16'(log0[4].a), log0[4].d}, {16'd2, 16'h0003});
         chk("sim_ph", {16'(log0[5].a), log0[5].d}, {16'd3, 16'h0002});
         chk("sim_ctrl", {16'(log0[6].a), log0[6].d}, {16'd1, 16'h0005});
      end

      // waitrequest held on P_H
      log0.delete();
      cmd_period = 32'h12345678;
      cmd_cont   = 1'b1;
      cmd_ien    = 1'b0;
      cmd_valid  = 1'b1;
      chk("wr_ready", 32'(cmd_ready0), 32'd1);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("wr_ph_visible", 32'(addr0), 32'd3);
      wait0 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("wr_hold", {12'h0, cs0, addr0, wd0}, {12'h0, 1'b1, 3'd3, 16'h1234});
      end
      wait0 = 1'b0;
      wait_idle0();
      chk("wr_nxfer", log0.size(), 32'd3);
      if (log0.size() == 3) begin
         chk("wr_pl", {16'(log0[0].a), log0[0].d}, {16'd2, 16'h5678});
         chk("wr_ph", {16'(log0[1].a), log0[1].d}, {16'd3, 16'h1234});
         chk("wr_ctrl", {16'(log0[2].a), log0[2].d}, {16'd1, 16'h0006});
         chk("wr_stall_len", log0[1].c - log0[0].c, 32'd4);
         chk("wr_ctrl_next", log0[2].c - log0[1].c, 32'd1);
      end

      // READ_LATENCY=3 and counter wrap
      tsnap1 = 32'hFFFF0000;
      n = n_ev1;
      raise1();
      wait_ev1(n);
      chk("lat3_latency", t_ev1 - t_irq1, 32'd13);
      chk("lat3_snapshot", snap_o1, 32'hFFFF0000);
      chk("lat3_count", 32'(cnt1), 32'd1);
      for (int j = 0; j < 16; j++) begin
         tick();
         n = n_ev1;
         raise1();
         wait_ev1(n);
         if (j == 14)
            chk("wrap_zero", 32'(cnt1), 32'd0);
      end
      chk("wrap_one", 32'(cnt1), 32'd1);

      // reset during WT_L
      tsnap0 = 32'h77778888;
      n = n_ev0;
      raise0();
      for (int j = 0; j < 4; j++)
         tick();
      chk("in_wt_l", {busy0, cs0}, 32'b10);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_bus", {cs0, wn0, addr0, wd0}, {1'b0, 1'b1, 3'd0, 16'h0});
      chk("rst_mid_evt", {ev0, busy0}, 32'd0);
      tick();
      reset_n = 1'b1;
      for (int j = 0; j < 4; j++)
         tick();
      chk("rst_after_busy", 32'(busy0), 32'd0);
      chk("rst_after_count", 32'(cnt0), 32'd0);
      chk("rst_no_event", n_ev0, n);
      log0.delete();
      prog0(32'h00000100, 1'b1, 1'b1);
      wait_idle0();
      chk("rearm_nxfer", log0.size(), 32'd3);
      if (log0.size() == 3)
         chk("rearm_ctrl", {16'(log0[2].a), log0[2].d}, {16'd1, 16'h0007});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
